// File: rtl/cube_window_sum.sv
// Sliding-window sum of the last WINDOW accepted cube samples: circular buffer plus running accumulator.
// Optional macro CUBE_WSUM_FLUSH_EN adds a 1-cycle `flush` input that clears the window like reset.
module cube_window_sum #(
    parameter int DATA_W = 32,
    parameter int WINDOW = 4,
    parameter int SUM_W  = 34
) (
    input  logic                         clock,
    input  logic                         reset,
`ifdef CUBE_WSUM_FLUSH_EN
    input  logic                         flush,
`endif
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [SUM_W-1:0]             out_sum,
    input  logic                         out_ready,
    output logic [$clog2(WINDOW+1)-1:0]  fill_cnt
);

    localparam int PTR_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int CNT_W = $clog2(WINDOW + 1);

    typedef enum logic {FILL, RUN} state_t;

    function automatic logic [SUM_W-1:0] zext(input logic [DATA_W-1:0] x);
        return SUM_W'(x);
    endfunction

    state_t                  state, state_nxt;
    logic [DATA_W-1:0]       samples [WINDOW];
    logic [PTR_W-1:0]        wr_ptr;
    logic [SUM_W-1:0]        acc;
    logic [SUM_W-1:0]        acc_nxt;
    logic                    flush_w;
    logic                    in_fire;
    logic                    out_fire;
    logic                    emit;
    logic                    last_fill;

`ifdef CUBE_WSUM_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // in_ready depends only on registered output state, never on in_valid
    assign in_ready  = !reset && !flush_w && (!out_valid || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_fill = (fill_cnt == CNT_W'(WINDOW - 1));

    // The oldest slot still holds zero during FILL because clearing wiped it
    assign acc_nxt = acc + zext(in_data) - zext(samples[wr_ptr]);

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        if (flush_w) begin
            state_nxt = FILL;
        end else if (in_fire) begin
            if (state == RUN) begin
                emit = 1'b1;
            end else if (last_fill) begin
                emit      = 1'b1;
                state_nxt = RUN;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush_w) begin
            for (int i = 0; i < WINDOW; i++) samples[i] <= '0;
            acc      <= '0;
            wr_ptr   <= '0;
            fill_cnt <= '0;
        end else if (in_fire) begin
            samples[wr_ptr] <= in_data;
            acc             <= acc_nxt;
            wr_ptr          <= (wr_ptr == PTR_W'(WINDOW - 1)) ? '0 : wr_ptr + 1'b1;
            if (fill_cnt < CNT_W'(WINDOW)) fill_cnt <= fill_cnt + 1'b1;
        end
    end

    // Output register: loads on every producing accept, holds under backpressure
    always_ff @(posedge clock) begin
        if (reset || flush_w) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_sum   <= acc_nxt;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cube_window_sum.sv
// Table-driven bench for cube_window_sum (DATA_W=32, WINDOW=4, SUM_W=34).
// Flush sequence is exercised only when CUBE_WSUM_FLUSH_EN is defined.
module tb_cube_window_sum;

    localparam int DATA_W = 32;
    localparam int WINDOW = 4;
    localparam int SUM_W  = 34;
    localparam int CNT_W  = $clog2(WINDOW + 1);

    logic                clock;
    logic                reset;
    logic                flush;
    logic                in_valid;
    logic [DATA_W-1:0]   in_data;
    logic                in_ready;
    logic                out_valid;
    logic [SUM_W-1:0]    out_sum;
    logic                out_ready;
    logic [CNT_W-1:0]    fill_cnt;

    int checks = 0;
    int errors = 0;

    cube_window_sum #(.DATA_W(DATA_W), .WINDOW(WINDOW), .SUM_W(SUM_W)) dut (
        .clock     (clock),
        .reset     (reset),
`ifdef CUBE_WSUM_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_ready (out_ready),
        .fill_cnt  (fill_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic              rst;
        logic              fl;
        logic              iv;
        logic [DATA_W-1:0] data;
        logic              ordy;
        logic              exp_rdy;
        logic              exp_ov;
        logic [SUM_W-1:0]  exp_sum;
        int                exp_fill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                                input logic [DATA_W-1:0] data, input logic ordy,
                                input logic exp_rdy, input logic exp_ov,
                                input logic [SUM_W-1:0] exp_sum, input int exp_fill);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.data = data; v.ordy = ordy;
        v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.exp_sum = exp_sum; v.exp_fill = exp_fill;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, check in_ready before the edge and outputs after it
    task automatic do_row(input vec_t v, input int idx);
        @(negedge clock);
        reset     = v.rst;
        flush     = v.fl;
        in_valid  = v.iv;
        in_data   = v.data;
        out_ready = v.ordy;
        #1;
        check($sformatf("in_ready[%0d]", idx), 64'(in_ready), 64'(v.exp_rdy));
        @(posedge clock);
        #1;
        check($sformatf("out_valid[%0d]", idx), 64'(out_valid), 64'(v.exp_ov));
        check($sformatf("fill_cnt[%0d]", idx), 64'(fill_cnt), 64'(v.exp_fill));
        if (v.exp_ov) check($sformatf("out_sum[%0d]", idx), 64'(out_sum), 64'(v.exp_sum));
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

        // Warm-up: 1,8,27,64,125,216
        vecs.push_back(mk(0,0,1,32'd1,  1, 1,0,34'd0,  1));
        vecs.push_back(mk(0,0,1,32'd8,  1, 1,0,34'd0,  2));
        vecs.push_back(mk(0,0,1,32'd27, 1, 1,0,34'd0,  3));
        vecs.push_back(mk(0,0,1,32'd64, 1, 1,1,34'd100,4));
        vecs.push_back(mk(0,0,1,32'd125,1, 1,1,34'd224,4));
        vecs.push_back(mk(0,0,1,32'd216,1, 1,1,34'd432,4));
        vecs.push_back(mk(0,0,0,32'd0,  1, 1,0,34'd0,  4));
        // Backpressure
        vecs.push_back(mk(1,0,0,32'd0,  1, 0,0,34'd0,  0));
        vecs.push_back(mk(0,0,1,32'd1,  1, 1,0,34'd0,  1));
        vecs.push_back(mk(0,0,1,32'd8,  1, 1,0,34'd0,  2));
        vecs.push_back(mk(0,0,1,32'd27, 1, 1,0,34'd0,  3));
        vecs.push_back(mk(0,0,1,32'd64, 1, 1,1,34'd100,4));
        vecs.push_back(mk(0,0,1,32'd125,0, 0,1,34'd100,4));
        vecs.push_back(mk(0,0,1,32'd125,0, 0,1,34'd100,4));
        vecs.push_back(mk(0,0,1,32'd125,0, 0,1,34'd100,4));
        vecs.push_back(mk(0,0,1,32'd125,1, 1,1,34'd224,4));
        vecs.push_back(mk(0,0,1,32'd216,1, 1,1,34'd432,4));
        vecs.push_back(mk(0,0,0,32'd0,  1, 1,0,34'd0,  4));
        // Max values
        vecs.push_back(mk(1,0,0,32'd0,  1, 0,0,34'd0,  0));
        vecs.push_back(mk(0,0,1,32'hFFFF_FFFF,1, 1,0,34'd0,1));
        vecs.push_back(mk(0,0,1,32'hFFFF_FFFF,1, 1,0,34'd0,2));
        vecs.push_back(mk(0,0,1,32'hFFFF_FFFF,1, 1,0,34'd0,3));
        vecs.push_back(mk(0,0,1,32'hFFFF_FFFF,1, 1,1,34'h3_FFFF_FFFC,4));
        vecs.push_back(mk(0,0,1,32'd0,  1, 1,1,34'h2_FFFF_FFFD,4));
        // Gapped input, then held output until consumed
        vecs.push_back(mk(1,0,0,32'd0,  1, 0,0,34'd0,  0));
        vecs.push_back(mk(0,0,1,32'd1,  1, 1,0,34'd0,  1));
        vecs.push_back(mk(0,0,0,32'd77, 1, 1,0,34'd0,  1));
        vecs.push_back(mk(0,0,0,32'd77, 1, 1,0,34'd0,  1));
        vecs.push_back(mk(0,0,1,32'd8,  1, 1,0,34'd0,  2));
        vecs.push_back(mk(0,0,0,32'd77, 1, 1,0,34'd0,  2));
        vecs.push_back(mk(0,0,0,32'd77, 1, 1,0,34'd0,  2));
        vecs.push_back(mk(0,0,1,32'd27, 1, 1,0,34'd0,  3));
        vecs.push_back(mk(0,0,0,32'd77, 1, 1,0,34'd0,  3));
        vecs.push_back(mk(0,0,0,32'd77, 1, 1,0,34'd0,  3));
        vecs.push_back(mk(0,0,1,32'd64, 0, 1,1,34'd100,4));
        vecs.push_back(mk(0,0,0,32'd0,  0, 0,1,34'd100,4));
        vecs.push_back(mk(0,0,0,32'd0,  0, 0,1,34'd100,4));
        vecs.push_back(mk(0,0,0,32'd0,  1, 1,0,34'd0,  4));
        // Reset mid-operation
        vecs.push_back(mk(1,0,0,32'd0,  1, 0,0,34'd0,  0));
        vecs.push_back(mk(0,0,1,32'd1,  1, 1,0,34'd0,  1));
        vecs.push_back(mk(0,0,1,32'd8,  1, 1,0,34'd0,  2));
        vecs.push_back(mk(0,0,1,32'd27, 1, 1,0,34'd0,  3));
        vecs.push_back(mk(0,0,1,32'd64, 1, 1,1,34'd100,4));
        vecs.push_back(mk(0,0,1,32'd125,1, 1,1,34'd224,4));
        vecs.push_back(mk(1,0,1,32'd999,1, 0,0,34'd0,  0));
        vecs.push_back(mk(0,0,1,32'd8,  1, 1,0,34'd0,  1));
        vecs.push_back(mk(0,0,1,32'd8,  1, 1,0,34'd0,  2));
        vecs.push_back(mk(0,0,1,32'd8,  1, 1,0,34'd0,  3));
        vecs.push_back(mk(0,0,1,32'd8,  1, 1,1,34'd32, 4));

        // Reset state, held for two cycles
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum",   64'(out_sum),   64'd0);
        check("rst_fill_cnt",  64'(fill_cnt),  64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        foreach (vecs[i]) do_row(vecs[i], i);

`ifdef CUBE_WSUM_FLUSH_EN
        // Flush collides with a valid sample and a pending output
        do_row(mk(1,0,0,32'd0,  1, 0,0,34'd0,  0), 100);
        do_row(mk(0,0,1,32'd1,  1, 1,0,34'd0,  1), 101);
        do_row(mk(0,0,1,32'd8,  1, 1,0,34'd0,  2), 102);
        do_row(mk(0,0,1,32'd27, 1, 1,0,34'd0,  3), 103);
        do_row(mk(0,0,1,32'd64, 0, 1,1,34'd100,4), 104);
        do_row(mk(0,1,1,32'd125,0, 0,0,34'd0,  0), 105);
        do_row(mk(0,0,1,32'd1,  1, 1,0,34'd0,  1), 106);
        do_row(mk(0,0,1,32'd1,  1, 1,0,34'd0,  2), 107);
        do_row(mk(0,0,1,32'd1,  1, 1,0,34'd0,  3), 108);
        do_row(mk(0,0,1,32'd1,  1, 1,1,34'd4,  4), 109);
`endif

        @(negedge clock);
        in_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
